// File: rtl/anim_pkg.sv
// Shared types and constants for the 7-segment animation scheduler.
package anim_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        BLANK = 2'd2
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_BLANK  = 8'hFF;

    // Highest set bit wins; result is one-hot, or zero when nothing is set.
    function automatic logic [3:0] prio_enc4(input logic [3:0] v);
        logic [3:0] r;
        r = 4'b0000;
        if (v[3])      r = 4'b1000;
        else if (v[2]) r = 4'b0100;
        else if (v[1]) r = 4'b0010;
        else if (v[0]) r = 4'b0001;
        return r;
    endfunction

endpackage

// File: rtl/anim_scheduler_tick_div.sv
// Free-running divider: counts 0..DIV-1 and emits a registered one-cycle tick on each wrap.
module tick_div #(
    parameter int DIV = 12
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         tick_q, tick_d;

    always_comb begin
        tick_d = (cnt_q == LAST);
        cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/anim_scheduler.sv
// Display arbiter for up to four 7-segment animations, with a forced blank gap
// on every ownership change and the shared scan/step tick generators.
module anim_scheduler
    import anim_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int SCAN_HZ     = 1000,
    parameter int STEP_HZ     = 3,
    parameter int BLANK_TICKS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [27:0] seg_in,
    input  logic [31:0] an_in,
    output logic [3:0]  grant,
    output logic        scan_tick,
    output logic        step_tick,
    output logic [6:0]  segmentos,
    output logic [7:0]  anodos,
    output logic        busy
);
    // state | meaning
    // IDLE  | no owner, pins blank
    // RUN   | grant_q owns the display
    // BLANK | changing owner, pins blank for BLANK_TICKS scan ticks

    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int STEP_DIV = CLK_HZ / STEP_HZ;
    localparam int BW = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_TICKS - 1);

    logic [3:0]    req_m_q, req_s_q;
    state_e        state_q, state_d;
    logic [3:0]    grant_q, grant_d;
    logic [BW-1:0] blank_cnt_q, blank_cnt_d;
    logic [6:0]    seg_q, seg_d;
    logic [7:0]    an_q, an_d;
    logic [3:0]    higher_mask;

    tick_div #(.DIV(SCAN_DIV)) u_scan_div (
        .clk  (clk),
        .rst  (rst),
        .tick (scan_tick)
    );

    tick_div #(.DIV(STEP_DIV)) u_step_div (
        .clk  (clk),
        .rst  (rst),
        .tick (step_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_m_q <= 4'b0000;
            req_s_q <= 4'b0000;
        end else begin
            req_m_q <= req;
            req_s_q <= req_m_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= 4'b0000;
            blank_cnt_q <= '0;
            seg_q       <= SEG_BLANK;
            an_q        <= AN_BLANK;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            blank_cnt_q <= blank_cnt_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    // Bits strictly above the one-hot owner, e.g. 0010 -> 1100.
    assign higher_mask = ~(grant_q | (grant_q - 4'd1));

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        blank_cnt_d = blank_cnt_q;
        case (state_q)
            IDLE: begin
                if (req_s_q != 4'b0000) begin
                    state_d = RUN;
                    grant_d = prio_enc4(req_s_q);
                end
            end
            RUN: begin
                if (((req_s_q & grant_q) == 4'b0000) ||
                    ((req_s_q & higher_mask) != 4'b0000)) begin
                    state_d     = BLANK;
                    grant_d     = 4'b0000;
                    blank_cnt_d = '0;
                end
            end
            BLANK: begin
                if (scan_tick) begin
                    if (blank_cnt_q == BLANK_LAST) begin
                        blank_cnt_d = '0;
                        grant_d     = prio_enc4(req_s_q);
                        state_d     = (req_s_q != 4'b0000) ? RUN : IDLE;
                    end else begin
                        blank_cnt_d = blank_cnt_q + BW'(1);
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                grant_d     = 4'b0000;
                blank_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        seg_d = SEG_BLANK;
        an_d  = AN_BLANK;
        busy  = (state_q != IDLE);
        if (state_q == RUN) begin
            for (int i = 0; i < 4; i++) begin
                if (grant_q[i]) begin
                    seg_d = seg_in[7*i +: 7];
                    an_d  = an_in[8*i +: 8];
                end
            end
        end
    end

    assign grant     = grant_q;
    assign segmentos = seg_q;
    assign anodos    = an_q;

endmodule

// File: tb/tb_anim_scheduler.sv
// Testbench for anim_scheduler: owner/blank-countdown model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_anim_scheduler;
    localparam int CLK_HZ      = 120;
    localparam int SCAN_HZ     = 10;
    localparam int STEP_HZ     = 2;
    localparam int BLANK_TICKS = 2;
    localparam int SCAN_DIV    = CLK_HZ / SCAN_HZ;
    localparam int STEP_DIV    = CLK_HZ / STEP_HZ;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [27:0] seg_in;
    logic [31:0] an_in;
    logic [3:0]  grant;
    logic        scan_tick, step_tick, busy;
    logic [6:0]  segmentos;
    logic [7:0]  anodos;

    int n_chk  = 0;
    int n_fail = 0;

    anim_scheduler #(
        .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .STEP_HZ(STEP_HZ), .BLANK_TICKS(BLANK_TICKS)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .seg_in(seg_in), .an_in(an_in),
        .grant(grant), .scan_tick(scan_tick), .step_tick(step_tick),
        .segmentos(segmentos), .anodos(anodos), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: owner index (-1 none) and scan ticks left in the blank gap.
    int         m_n_q, m_n_d, m_own_q, m_own_d, m_bl_q, m_bl_d;
    logic [3:0] m_rs1_q, m_rs1_d, m_rs2_q, m_rs2_d;
    logic [6:0] m_seg_q, m_seg_d;
    logic [7:0] m_an_q, m_an_d;
    logic       m_scan;

    function automatic int top_bit(input logic [3:0] v);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    always_comb begin
        m_scan  = (m_n_q > 0) && (m_n_q % SCAN_DIV == 0);
        m_n_d   = m_n_q + 1;
        m_rs1_d = req;
        m_rs2_d = m_rs1_q;
        m_own_d = m_own_q;
        m_bl_d  = m_bl_q;
        m_seg_d = 7'h7F;
        m_an_d  = 8'hFF;
        if (m_own_q >= 0) begin
            m_seg_d = seg_in[7*m_own_q +: 7];
            m_an_d  = an_in[8*m_own_q +: 8];
            if (!m_rs2_q[m_own_q] || ((32'(m_rs2_q) >> (m_own_q + 1)) != 0)) begin
                m_own_d = -1;
                m_bl_d  = BLANK_TICKS;
            end
        end else if (m_bl_q > 0) begin
            if (m_scan) begin
                m_bl_d = m_bl_q - 1;
                if (m_bl_q == 1) m_own_d = top_bit(m_rs2_q);
            end
        end else begin
            m_own_d = top_bit(m_rs2_q);
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_n_q <= 0; m_rs1_q <= 4'b0; m_rs2_q <= 4'b0;
            m_own_q <= -1; m_bl_q <= 0; m_seg_q <= 7'h7F; m_an_q <= 8'hFF;
        end else begin
            m_n_q <= m_n_d; m_rs1_q <= m_rs1_d; m_rs2_q <= m_rs2_d;
            m_own_q <= m_own_d; m_bl_q <= m_bl_d; m_seg_q <= m_seg_d; m_an_q <= m_an_d;
        end
    end

    always @(negedge clk) begin
        check("cmp_grant", 32'(grant), (m_own_q >= 0) ? 32'(1 << m_own_q) : 32'd0);
        check("cmp_busy", 32'(busy), 32'((m_own_q >= 0) || (m_bl_q > 0)));
        check("cmp_scan", 32'(scan_tick), 32'(m_scan));
        check("cmp_step", 32'(step_tick), 32'((m_n_q > 0) && (m_n_q % STEP_DIV == 0)));
        check("cmp_seg", 32'(segmentos), 32'(m_seg_q));
        check("cmp_an", 32'(anodos), 32'(m_an_q));
    end

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    // Count scan ticks seen while busy with no owner, until a new owner or IDLE.
    task automatic wait_regrant(input string name, input logic [3:0] exp_grant,
                                input int exp_ticks, input logic [6:0] exp_seg,
                                input logic [7:0] exp_an);
        int ticks = 0;
        int k = 0;
        while (busy && grant == 4'b0000 && k < 200) begin
            if (scan_tick) ticks++;
            step();
            k++;
        end
        check({name, "_in_time"}, 32'(k < 200), 32'd1);
        check({name, "_ticks"}, 32'(ticks), 32'(exp_ticks));
        check({name, "_grant"}, 32'(grant), 32'(exp_grant));
        check({name, "_seg_gap"}, 32'(segmentos), 32'h7F);
        step();
        check({name, "_seg"}, 32'(segmentos), 32'(exp_seg));
        check({name, "_an"}, 32'(anodos), 32'(exp_an));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        rst    = 1'b1;
        req    = 4'b0000;
        seg_in = {7'h21, 7'h24, 7'h08, 7'h79};
        an_in  = {8'h7F, 8'hFB, 8'hBF, 8'hFE};
        repeat (3) step();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_seg", 32'(segmentos), 32'h7F);
        check("rst_an", 32'(anodos), 32'hFF);
        check("rst_scan", 32'(scan_tick), 32'h0);

        // 1: free-running ticks with no requests
        rst = 1'b0;
        for (int k = 1; k <= 61; k++) begin
            step();
            if (k == 11) check("t1_scan11", 32'(scan_tick), 32'h0);
            if (k == 12) check("t1_scan12", 32'(scan_tick), 32'h1);
            if (k == 24) check("t1_scan24", 32'(scan_tick), 32'h1);
            if (k == 59) check("t1_step59", 32'(step_tick), 32'h0);
            if (k == 60) check("t1_step60", 32'(step_tick), 32'h1);
        end
        check("t1_grant", 32'(grant), 32'h0);
        check("t1_an", 32'(anodos), 32'hFF);

        // 2: single request, three edges to grant, pins one edge later
        req = 4'b0010;
        step(); step();
        check("t2_grant_e2", 32'(grant), 32'h0);
        step();
        check("t2_grant_e3", 32'(grant), 32'b0010);
        check("t2_busy", 32'(busy), 32'h1);
        check("t2_seg_e3", 32'(segmentos), 32'h7F);
        step();
        check("t2_seg_e4", 32'(segmentos), 32'h08);
        check("t2_an_e4", 32'(anodos), 32'hBF);
        repeat (5) step();

        // 3: higher request preempts through a blank gap
        req = 4'b1010;
        step(); step();
        check("t3_grant_e2", 32'(grant), 32'b0010);
        step();
        check("t3_grant_e3", 32'(grant), 32'h0);
        wait_regrant("t3", 4'b1000, 2, 7'h21, 8'h7F);

        // 4: lower request ignored, then owner drops
        req = 4'b1001;
        repeat (30) step();
        check("t4_hold_grant", 32'(grant), 32'b1000);
        check("t4_hold_seg", 32'(segmentos), 32'h21);
        req = 4'b0001;
        repeat (3) step();
        check("t4_drop_grant", 32'(grant), 32'h0);
        wait_regrant("t4", 4'b0001, 2, 7'h79, 8'hFE);

        // 5: requests vanish during the gap -> IDLE
        req = 4'b0101;
        repeat (3) step();
        check("t5_blank", 32'(grant), 32'h0);
        req = 4'b0000;
        wait_regrant("t5", 4'b0000, 2, 7'h7F, 8'hFF);
        check("t5_busy", 32'(busy), 32'h0);

        // 6: reset mid-RUN, then direct re-grant from IDLE
        req = 4'b0100;
        step(); step();
        check("t6_grant_e2", 32'(grant), 32'h0);
        step();
        check("t6_grant_e3", 32'(grant), 32'b0100);
        step();
        check("t6_seg_e4", 32'(segmentos), 32'h24);
        repeat (4) step();
        rst = 1'b1;
        #1;
        check("t6_rst_grant", 32'(grant), 32'h0);
        check("t6_rst_seg", 32'(segmentos), 32'h7F);
        check("t6_rst_an", 32'(anodos), 32'hFF);
        check("t6_rst_busy", 32'(busy), 32'h0);
        check("t6_rst_ticks", 32'({scan_tick, step_tick}), 32'h0);
        step();
        rst = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            step();
            if (k == 2)  check("t6_regrant_e2", 32'(grant), 32'h0);
            if (k == 3)  check("t6_regrant_e3", 32'(grant), 32'b0100);
            if (k == 4)  check("t6_regrant_seg", 32'(segmentos), 32'h24);
            if (k == 11) check("t6_scan11", 32'(scan_tick), 32'h0);
            if (k == 12) check("t6_scan12", 32'(scan_tick), 32'h1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/anim_scheduler.md
# anim_scheduler

Top-level controller for the 7-segment animation subsystem. It arbitrates the single display (7 cathodes, 8 anodes, active-low) between up to four animation blocks requested by slide switches. It generates the slow step tick and the per-digit scan tick those animations consume. On every ownership change it forces a blanking gap, so one animation's frame never bleeds into the next.

## Interface
Parameters:
- CLK_HZ, 100_000_000, input clock frequency
- SCAN_HZ, 1000, per-digit scan tick rate; SCAN_DIV = CLK_HZ/SCAN_HZ
- STEP_HZ, 3, animation step tick rate; STEP_DIV = CLK_HZ/STEP_HZ
- BLANK_TICKS, 8, scan ticks spent blank on every switchover (≥1)

Ports (one clock, `clk`; reset `rst` is asynchronous, active-high):
- clk  in  1  system clock
- rst  in  1  async active-high reset
- req  in  4  animation requests from switches, asynchronous; bit 3 highest priority
- seg_in  in  28  cathode patterns, requester i on [7i+6:7i], active-low
- an_in  in  32  anode patterns, requester i on [8i+7:8i], active-low
- grant  out  4  one-hot enable to the owning animation; 0 when none
- scan_tick  out  1  one-cycle pulse every SCAN_DIV cycles
- step_tick  out  1  one-cycle pulse every STEP_DIV cycles
- segmentos  out  7  muxed cathodes to pins
- anodos  out  8  muxed anodes to pins
- busy  out  1  high in RUN or BLANK

## Operation
- `req` passes through a 2-flop synchronizer per bit; the FSM sees only `req_s`.
- Tick dividers run free from reset. Each counter counts 0..DIV-1, pulses when it equals DIV-1, then wraps to 0. Counter width is $clog2(DIV). Tick generation is not affected by FSM state.
- FSM states:
  - IDLE: grant=0, outputs blank. If req_s≠0, go to RUN with grant set to the highest set bit of req_s.
  - RUN: grant held.
    - If the granted bit of req_s drops, go to BLANK.
    - If a higher-index bit of req_s rises, go to BLANK.
    - If both happen in the same cycle, go to BLANK (single transition).
    - A lower-index bit rising is ignored.
    - On entry to BLANK, grant=0 and blank_cnt=0.
  - BLANK: grant=0, outputs blank. blank_cnt increments on each scan_tick.
    - When blank_cnt reaches BLANK_TICKS-1 and a scan_tick occurs, re-arbitrate on the current req_s.
    - If req_s≠0, go to RUN with the highest set bit granted; otherwise go to IDLE.
    - Request changes during BLANK only affect this final arbitration.
- Animations reset themselves while their grant is low, so BLANK guarantees a restart from frame 0.
- Output mux is registered:
  - RUN: segmentos/anodos = seg_in/an_in slice of the granted index.
  - Otherwise: segmentos=7'h7F, anodos=8'hFF.
- busy = (state≠IDLE).

## Timing
- Reset values: grant=0, busy=0, scan_tick=0, step_tick=0, segmentos=7'h7F, anodos=8'hFF, state=IDLE, all counters 0, synchronizer flops 0. Reset takes effect immediately, including mid-RUN or mid-BLANK.
- First scan_tick fires in cycle SCAN_DIV after rst deasserts; first step_tick fires in cycle STEP_DIV after deassertion.
- Request latency:
  - 2 cycles through the synchronizer.
  - Grant changes on the next edge after that (3 edges from the req edge to grant).
  - Pins follow grant one edge later.
- IDLE→RUN has no blank gap. RUN→RUN (ownership change) always passes through BLANK; BLANK length is BLANK_TICKS scan ticks.
- grant is one-hot or zero in every cycle. It never changes directly from one nonzero value to another.
- A scan_tick and a BLANK exit in the same cycle: the exit is taken and the new owner's data appears on pins the following edge.

## Structure
- Package anim_pkg:
  - state enum {IDLE, RUN, BLANK}
  - SEG_BLANK=7'h7F, AN_BLANK=8'hFF
  - prio_enc4 function: highest set bit → one-hot
- Sub-module tick_div (parameter DIV, ports clk, rst, tick), instantiated twice for scan and step ticks.
- Synchronizer, FSM and output mux stay in anim_scheduler.

## Test plan
Bench parameters: CLK_HZ=120, SCAN_HZ=10, STEP_HZ=2, BLANK_TICKS=2. This gives SCAN_DIV=12 and STEP_DIV=60.

1. Release reset, req=0 → scan_tick pulses at cycles 12, 24, …; step_tick at 60, 120; grant=0, segmentos=7F, anodos=FF throughout.
2. req=4'b0010, seg_in[13:7]=7'h08, an_in[15:8]=8'hBF → grant=0010 three edges after the req edge; pins read 08/BF one edge later; busy=1.
3. While in case 2, raise req[3] with seg_in[27:21]=7'h21 → grant=0 for exactly 2 scan ticks with pins 7F/FF; then grant=1000 and pins show 21.
4. While owned by bit 3, raise req[0] → no change to grant or pins. Then drop req[3] → BLANK for 2 scan ticks, then grant=0001.
5. In BLANK, drop all req → after 2 scan ticks state returns to IDLE, busy=0, grant=0.
6. Assert rst mid-RUN for one cycle → grant=0, pins 7F/FF, and tick counters restart, all immediately. After release, an IDLE→RUN re-grant occurs with no blank gap.
